// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one simple_alu between two requesters.
// The winner's parallel operation is serialized onto the ALU's 4-cycle opcode_valid protocol.
module alu_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            op0,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] b0,
  input  logic [1:0]            op1,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] b1,
  output logic [1:0]            gnt,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  opcode_valid,
  output logic                  opcode,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  done,
  input  logic                  overflow,
  input  logic [DATA_WIDTH-1:0] result,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [1:0]            issue_cnt_q, issue_cnt_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  last_q, last_d;
  logic                  win_q, win_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_overflow_q, rsp_overflow_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  busy_q, busy_d;
  logic                  opv_q, opv_d;
  logic                  opc_q, opc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  win_sel;

  // Handshake: a requester holds req[i] and its operands stable until gnt[i]
  // pulses; operands are captured on that edge. rsp_valid[i] pulses once per
  // grant, and req[i] still high afterwards counts as a fresh request.
  // On a tie the requester not granted last wins.
  assign win_sel = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d        = state_q;
    issue_cnt_d    = issue_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    last_d         = last_q;
    win_d          = win_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    gnt_d          = 2'b00;
    rsp_valid_d    = 2'b00;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_timeout_d  = rsp_timeout_q;
    opv_d          = 1'b0;
    opc_d          = 1'b0;
    data_d         = '0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win_d       = win_sel;
          last_d      = win_sel;
          op_d        = win_sel ? op1 : op0;
          a_d         = win_sel ? a1 : a0;
          b_d         = win_sel ? b1 : b0;
          gnt_d       = win_sel ? 2'b10 : 2'b01;
          opv_d       = 1'b1;
          data_d      = win_sel ? a1 : a0;
          opc_d       = win_sel ? op1[0] : op0[0];
          issue_cnt_d = 2'd0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + 2'd1;
        if (issue_cnt_q == 2'd3) begin
          wait_cnt_d = 8'd0;
          state_d    = WAIT;
        end else begin
          // Outputs are registered, so this selects the beat for issue_cnt+1.
          opv_d  = 1'b1;
          data_d = (issue_cnt_q == 2'd0) ? a_q : b_q;
          opc_d  = (issue_cnt_q == 2'd0) ? op_q[0] : op_q[1];
        end
      end
      WAIT: begin
        if (done) begin
          rsp_result_d   = result;
          rsp_overflow_d = overflow;
          rsp_timeout_d  = 1'b0;
          rsp_valid_d    = win_q ? 2'b10 : 2'b01;
          state_d        = RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          rsp_result_d   = '0;
          rsp_overflow_d = 1'b0;
          rsp_timeout_d  = 1'b1;
          rsp_valid_d    = win_q ? 2'b10 : 2'b01;
          state_d        = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      issue_cnt_q    <= 2'd0;
      wait_cnt_q     <= 8'd0;
      last_q         <= 1'b1;
      win_q          <= 1'b0;
      op_q           <= 2'b00;
      a_q            <= '0;
      b_q            <= '0;
      gnt_q          <= 2'b00;
      rsp_valid_q    <= 2'b00;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
      opv_q          <= 1'b0;
      opc_q          <= 1'b0;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      issue_cnt_q    <= issue_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      last_q         <= last_d;
      win_q          <= win_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      gnt_q          <= gnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_timeout_q  <= rsp_timeout_d;
      busy_q         <= busy_d;
      opv_q          <= opv_d;
      opc_q          <= opc_d;
      data_q         <= data_d;
    end
  end

  assign gnt          = gnt_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign busy         = busy_q;
  assign opcode_valid = opv_q;
  assign opcode       = opc_q;
  assign data         = data_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: stub ALU, directed scenarios, randomized traffic,
// and a timeline-based reference model compared against the DUT every cycle.
module tb_alu_arbiter;
  localparam int W       = 8;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   req = 2'b00, op0 = 2'b00, op1 = 2'b00;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]   gnt, rsp_valid, state_dbg;
  logic [W-1:0] rsp_result, data;
  logic         rsp_overflow, rsp_timeout, busy, opcode_valid, opcode;
  logic         done = 1'b0, overflow = 1'b0;
  logic [W-1:0] result = '0;

  alu_arbiter #(.DATA_WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req),
    .op0(op0), .a0(a0), .b0(b0), .op1(op1), .a1(a1), .b1(b1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .busy(busy),
    .opcode_valid(opcode_valid), .opcode(opcode), .data(data),
    .done(done), .overflow(overflow), .result(result), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- stub ALU ----------------
  function automatic logic [8:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {8'h00, ^{a, b}};
      default: return {1'b0, 8'hAA};
    endcase
  endfunction

  int           stub_delay  = 0;   // WAIT cycle index of done; negative = random
  bit           stray_idle  = 1'b0;
  bit           stray_issue = 1'b0;
  int           s_n = 0, s_cnt = 0, s_k = 0;
  bit           s_armed = 1'b0;
  logic [1:0]   s_op = 2'b00;
  logic [W-1:0] s_a = '0, s_b = '0;
  logic [8:0]   s_r;

  always @(negedge clk) begin
    done = 1'b0;
    if (reset) begin
      s_n = 0;
      s_armed = 1'b0;
    end else if (opcode_valid) begin
      s_armed = 1'b0;
      if (s_n < 2) s_a = data; else s_b = data;
      if (s_n == 0) s_op[0] = opcode;
      if (s_n == 2) s_op[1] = opcode;
      if (stray_issue && s_n == 1) begin
        done = 1'b1; result = 8'hEE; overflow = 1'b1; stray_issue = 1'b0;
      end
      s_n++;
      if (s_n == 4) begin
        s_n = 0; s_armed = 1'b1; s_cnt = 0;
        s_k = (stub_delay < 0) ? int'($urandom_range(0, TIMEOUT + 1)) : stub_delay;
      end
    end else begin
      s_n = 0;
      if (s_armed) begin
        if (s_cnt == s_k) begin
          s_r = alu_fn(s_op, s_a, s_b);
          done = 1'b1; result = s_r[7:0]; overflow = s_r[8]; s_armed = 1'b0;
        end
        s_cnt++;
      end else if (stray_idle) begin
        done = 1'b1; result = 8'h77; overflow = 1'b1; stray_idle = 1'b0;
      end
    end
  end

  // ---------------- reference model (time since arbitration) ----------------
  // m_t = 0 idle; 1..4 issue beats; >=5 waiting (WAIT index m_t-5); m_resp = response cycle.
  int           m_t = 0;
  bit           m_resp = 1'b0, m_last = 1'b1, m_win = 1'b0, m_valid = 1'b0;
  logic [1:0]   m_op = 2'b00;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [1:0]   exp_gnt = '0, exp_rv = '0;
  logic [W-1:0] exp_data = '0, exp_res = '0;
  logic         exp_ov = 1'b0, exp_opc = 1'b0, exp_busy = 1'b0, exp_ovf = 1'b0, exp_to = 1'b0;

  always @(posedge clk) begin
    exp_gnt = 2'b00; exp_rv = 2'b00; exp_ov = 1'b0; exp_data = '0; exp_opc = 1'b0;
    if (reset) begin
      m_t = 0; m_resp = 1'b0; m_last = 1'b1; m_valid = 1'b1;
      exp_busy = 1'b0; exp_res = '0; exp_ovf = 1'b0; exp_to = 1'b0;
    end else if (m_valid) begin
      if (m_resp) begin
        m_resp = 1'b0; m_t = 0; exp_busy = 1'b0;
      end else if (m_t == 0) begin
        if (req != 2'b00) begin
          m_win  = (req == 2'b11) ? !m_last : req[1];
          m_last = m_win;
          m_op   = m_win ? op1 : op0;
          m_a    = m_win ? a1 : a0;
          m_b    = m_win ? b1 : b0;
          m_t    = 1;
          exp_gnt[m_win] = 1'b1;
          exp_busy = 1'b1; exp_ov = 1'b1; exp_data = m_a; exp_opc = m_op[0];
        end else begin
          exp_busy = 1'b0;
        end
      end else if (m_t < 4) begin
        m_t++;
        exp_ov   = 1'b1;
        exp_data = (m_t <= 2) ? m_a : m_b;
        exp_opc  = (m_t <= 2) ? m_op[0] : m_op[1];
      end else if (m_t >= 5 && done) begin
        m_resp = 1'b1; exp_rv[m_win] = 1'b1;
        exp_res = result; exp_ovf = overflow; exp_to = 1'b0;
      end else if (m_t - 5 == TIMEOUT - 1) begin
        m_resp = 1'b1; exp_rv[m_win] = 1'b1;
        exp_res = '0; exp_ovf = 1'b0; exp_to = 1'b1;
      end else begin
        m_t++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("gnt",          32'(gnt),          32'(exp_gnt));
      check("rsp_valid",    32'(rsp_valid),    32'(exp_rv));
      check("rsp_result",   32'(rsp_result),   32'(exp_res));
      check("rsp_overflow", 32'(rsp_overflow), 32'(exp_ovf));
      check("rsp_timeout",  32'(rsp_timeout),  32'(exp_to));
      check("busy",         32'(busy),         32'(exp_busy));
      check("opcode_valid", 32'(opcode_valid), 32'(exp_ov));
      check("opcode",       32'(opcode),       32'(exp_opc));
      check("data",         32'(data),         32'(exp_data));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input int lim, output logic [1:0] g, output int c);
    bit seen;
    seen = 1'b0; g = 2'b00; c = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (|gnt) begin seen = 1'b1; g = gnt; c = cyc; end
    end
    check("gnt_seen", 32'(seen), 1);
  endtask

  task automatic wait_rsp(input int lim, output logic [1:0] rv, output logic [W-1:0] res,
                          output logic ovf, output logic to, output int c);
    bit seen;
    seen = 1'b0; rv = 2'b00; res = '0; ovf = 1'b0; to = 1'b0; c = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (|rsp_valid) begin
        seen = 1'b1; rv = rsp_valid; res = rsp_result; ovf = rsp_overflow; to = rsp_timeout; c = cyc;
      end
    end
    check("rsp_seen", 32'(seen), 1);
  endtask

  // Called on the negedge of the first issue beat; samples four beats plus one.
  task automatic grab_issue(output logic [31:0] d, output logic [3:0] o, output int nv);
    d = '0; o = '0; nv = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      d = {d[23:0], data};
      o = {o[2:0], opcode};
      nv += int'(opcode_valid);
    end
    @(negedge clk);
    nv += int'(opcode_valid);
  endtask

  task automatic rand_ops(input int i);
    if (i == 0) begin
      op0 = 2'($urandom_range(0, 3)); a0 = 8'($urandom); b0 = 8'($urandom);
    end else begin
      op1 = 2'($urandom_range(0, 3)); a1 = 8'($urandom); b1 = 8'($urandom);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [1:0]   g, rv;
  logic [W-1:0] res, r0, r1;
  logic         ovf, to;
  int           gc, rc, nv, ng, nr, cnt_rv, cnt_g, cnt_b;
  logic [31:0]  d;
  logic [3:0]   o, ord;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_gnt",   32'(gnt), 0);
    check("reset_busy",  32'(busy), 0);
    check("reset_data",  32'(data), 0);
    check("reset_opv",   32'(opcode_valid), 0);
    check("reset_rsp",   32'(rsp_result), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single ADD: 0xFF + 0x01, done in WAIT cycle 1.
    stub_delay = 1;
    op0 = 2'b00; a0 = 8'hFF; b0 = 8'h01; req = 2'b01;
    wait_gnt(10, g, gc);
    req = 2'b00;
    check("add_gnt", 32'(g), 32'h1);
    grab_issue(d, o, nv);
    check("add_data", d, 32'hFFFF0101);
    check("add_opc", 32'(o), 32'h0);
    check("add_nvalid", 32'(nv), 4);
    wait_rsp(20, rv, res, ovf, to, rc);
    check("add_rv", 32'(rv), 32'h1);
    check("add_res", 32'(res), 32'h00);
    check("add_ovf", 32'(ovf), 1);
    check("add_to", 32'(to), 0);
    check("add_latency", 32'(rc - gc), 6);
    repeat (3) @(negedge clk);

    // Opcode serialization: COMP from requester 1, done in WAIT cycle 0.
    stub_delay = 0;
    op1 = 2'b11; a1 = 8'h5A; b1 = 8'h0F; req = 2'b10;
    wait_gnt(10, g, gc);
    req = 2'b00;
    check("comp_gnt", 32'(g), 32'h2);
    grab_issue(d, o, nv);
    check("comp_data", d, 32'h5A5A0F0F);
    check("comp_opc", 32'(o), 32'hF);
    check("comp_nvalid", 32'(nv), 4);
    wait_rsp(20, rv, res, ovf, to, rc);
    check("comp_rv", 32'(rv), 32'h2);
    check("comp_res", 32'(res), 32'hAA);
    check("comp_latency", 32'(rc - gc), 5);
    repeat (3) @(negedge clk);

    // Contention: both requesters held for four transactions.
    op0 = 2'b00; a0 = 8'h10; b0 = 8'h20;
    op1 = 2'b01; a1 = 8'h30; b1 = 8'h10;
    req = 2'b11;
    ord = '0; ng = 0; nr = 0; r0 = '0; r1 = '0;
    for (int i = 0; i < 200 && nr < 4; i++) begin
      @(negedge clk);
      if (|gnt) begin ord = {ord[2:0], gnt[1]}; ng++; end
      if (|rsp_valid) begin
        if (rsp_valid[0]) r0 = rsp_result; else r1 = rsp_result;
        nr++;
        if (nr == 4) req = 2'b00;
      end
    end
    check("cont_ngnt", 32'(ng), 4);
    check("cont_nrsp", 32'(nr), 4);
    check("cont_order", 32'(ord), 32'h5);
    check("cont_res0", 32'(r0), 32'h30);
    check("cont_res1", 32'(r1), 32'h20);
    repeat (3) @(negedge clk);

    // Timeout: done never arrives.
    stub_delay = 1000;
    op0 = 2'b01; a0 = 8'h03; b0 = 8'h01; req = 2'b01;
    wait_gnt(10, g, gc);
    req = 2'b00;
    wait_rsp(40, rv, res, ovf, to, rc);
    check("to_rv", 32'(rv), 32'h1);
    check("to_flag", 32'(to), 1);
    check("to_res", 32'(res), 32'h00);
    check("to_latency", 32'(rc - gc), 12);
    stub_delay = 0;
    op0 = 2'b00; a0 = 8'h12; b0 = 8'h34; req = 2'b01;
    wait_gnt(10, g, gc);
    req = 2'b00;
    wait_rsp(20, rv, res, ovf, to, rc);
    check("after_to_res", 32'(res), 32'h46);
    check("after_to_flag", 32'(to), 0);
    repeat (3) @(negedge clk);

    // Stray done in IDLE, then in ISSUE; the real done comes in WAIT cycle 2.
    stray_idle = 1'b1;
    cnt_rv = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt_rv += int'(|rsp_valid);
      cnt_b  += int'(busy);
    end
    check("stray_idle_rsp", 32'(cnt_rv), 0);
    check("stray_idle_busy", 32'(cnt_b), 0);
    stray_issue = 1'b1; stub_delay = 2;
    op0 = 2'b01; a0 = 8'h50; b0 = 8'h20; req = 2'b01;
    wait_gnt(10, g, gc);
    req = 2'b00;
    wait_rsp(20, rv, res, ovf, to, rc);
    check("stray_res", 32'(res), 32'h30);
    check("stray_ovf", 32'(ovf), 0);
    check("stray_latency", 32'(rc - gc), 7);
    repeat (3) @(negedge clk);

    // Reset mid-WAIT aborts silently and restores requester-0 priority.
    stub_delay = 1000;
    op0 = 2'b00; a0 = 8'h01; b0 = 8'h02; req = 2'b01;
    wait_gnt(10, g, gc);
    req = 2'b00;
    repeat (6) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rv", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_opv", 32'(opcode_valid), 0);
    check("rst_res", 32'(rsp_result), 0);
    cnt_rv = 0; cnt_g = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt_rv += int'(|rsp_valid);
      cnt_g  += int'(|gnt);
    end
    check("rst_no_rsp", 32'(cnt_rv), 0);
    check("rst_no_gnt", 32'(cnt_g), 0);
    stub_delay = 0;
    op0 = 2'b00; a0 = 8'h01; b0 = 8'h01;
    op1 = 2'b00; a1 = 8'h02; b1 = 8'h02;
    req = 2'b11;
    wait_gnt(10, g, gc);
    req = 2'b10;
    check("rst_tie_gnt", 32'(g), 32'h1);
    wait_gnt(30, g, gc);
    req = 2'b00;
    check("rst_second_gnt", 32'(g), 32'h2);
    repeat (20) @(negedge clk);

    // Randomized traffic against the model.
    stub_delay = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) stray_idle = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (gnt[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          rand_ops(i);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          rand_ops(i);
        end else if (req[i] && $urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    reset = 1'b0;
    req = 2'b00;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
